imm_encoder: RTL and testbench

IMM_ENCODER -- requirements
Module: imm_encoder

---
 rtl/imm_encoder.sv | 161 ++++++++++++++++
 tb/tb_imm_encoder.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/imm_encoder.sv
// Immediate encoder: range-checks a 32-bit offset against a compressed
// immediate format and emits one beat, or two high-then-low beats for BL.
module imm_encoder (
   input  logic        CLK,
   input  logic        RESETn,
   input  logic        IN_VALID,
   output logic        IN_READY,
   input  logic [2:0]  FMT,
   input  logic [31:0] VALUE,
   output logic        OUT_VALID,
   input  logic        OUT_READY,
   output logic [10:0] OUT_FIELD,
   output logic        OUT_LAST,
   output logic        OUT_ERR
);

   localparam logic [2:0] FMT_IMM3  = 3'd0;
   localparam logic [2:0] FMT_IMM5  = 3'd1;
   localparam logic [2:0] FMT_IMM8  = 3'd2;
   localparam logic [2:0] FMT_IMM11 = 3'd3;
   localparam logic [2:0] FMT_BL    = 3'd4;

   typedef enum logic [1:0] {
      IDLE,
      SINGLE,
      BL_HI,
      BL_LO
   } state_t;

   state_t      state_q, state_d;
   logic        ready_q, ready_d;
   logic        valid_q, valid_d;
   logic [10:0] field_q, field_d;
   logic        last_q,  last_d;
   logic        err_q,   err_d;
   logic [10:0] lo_q,    lo_d;

   logic        enc_ok;
   logic        enc_bl;
   logic [10:0] enc_hi;
   logic [10:0] enc_lo;
   logic        accept;
   logic        beat_done;

   // Signed formats: every bit above the field must replicate its sign bit.
   always_comb begin
      enc_ok = 1'b0;
      enc_bl = 1'b0;
      enc_hi = '0;
      enc_lo = '0;
      case (FMT)
         FMT_IMM3: begin
            enc_ok = (VALUE[31:3] == '0);
            enc_hi = {8'b0, VALUE[2:0]};
         end
         FMT_IMM5: begin
            enc_ok = (VALUE[31:7] == '0) && (VALUE[1:0] == 2'b00);
            enc_hi = {6'b0, VALUE[6:2]};
         end
         FMT_IMM8: begin
            enc_ok = !VALUE[0] && (VALUE[31:9] == {23{VALUE[8]}});
            enc_hi = {3'b0, VALUE[8:1]};
         end
         FMT_IMM11: begin
            enc_ok = !VALUE[0] && (VALUE[31:12] == {20{VALUE[11]}});
            enc_hi = VALUE[11:1];
         end
         FMT_BL: begin
            enc_bl = 1'b1;
            enc_ok = !VALUE[0] && (VALUE[31:23] == {9{VALUE[22]}});
            enc_hi = VALUE[22:12];
            enc_lo = VALUE[11:1];
         end
         default: begin
            enc_ok = 1'b0;
         end
      endcase
   end

   // ready_q is only ever set while in IDLE, so it alone qualifies accept.
   assign accept    = ready_q && IN_VALID;
   assign beat_done = valid_q && OUT_READY;

   always_comb begin
      state_d = state_q;
      valid_d = valid_q;
      field_d = field_q;
      last_d  = last_q;
      err_d   = err_q;
      lo_d    = lo_q;
      unique case (state_q)
         IDLE: begin
            if (accept) begin
               valid_d = 1'b1;
               if (enc_bl && enc_ok) begin
                  state_d = BL_HI;
                  field_d = enc_hi;
                  last_d  = 1'b0;
                  err_d   = 1'b0;
                  lo_d    = enc_lo;
               end else begin
                  state_d = SINGLE;
                  field_d = enc_ok ? enc_hi : 11'd0;
                  last_d  = 1'b1;
                  err_d   = !enc_ok;
               end
            end
         end
         BL_HI: begin
            if (beat_done) begin
               state_d = BL_LO;
               field_d = lo_q;
               last_d  = 1'b1;
               err_d   = 1'b0;
            end
         end
         SINGLE, BL_LO: begin
            if (beat_done) begin
               state_d = IDLE;
               valid_d = 1'b0;
               field_d = '0;
               last_d  = 1'b0;
               err_d   = 1'b0;
               lo_d    = '0;
            end
         end
         default: begin
            state_d = IDLE;
            valid_d = 1'b0;
         end
      endcase
      ready_d = (state_d == IDLE);
   end

   always_ff @(posedge CLK or negedge RESETn) begin
      if (!RESETn) begin
         state_q <= IDLE;
         ready_q <= 1'b0;
         valid_q <= 1'b0;
         field_q <= '0;
         last_q  <= 1'b0;
         err_q   <= 1'b0;
         lo_q    <= '0;
      end else begin
         state_q <= state_d;
         ready_q <= ready_d;
         valid_q <= valid_d;
         field_q <= field_d;
         last_q  <= last_d;
         err_q   <= err_d;
         lo_q    <= lo_d;
      end
   end

   assign IN_READY  = ready_q;
   assign OUT_VALID = valid_q;
   assign OUT_FIELD = field_q;
   assign OUT_LAST  = last_q;
   assign OUT_ERR   = err_q;

endmodule

// File: tb/tb_imm_encoder.sv
// Scoreboard bench for imm_encoder: directed vectors push expected beats,
// a negedge monitor pops and compares every completed output beat.
module tb_imm_encoder;

   logic        CLK;
   logic        RESETn;
   logic        IN_VALID;
   logic        IN_READY;
   logic [2:0]  FMT;
   logic [31:0] VALUE;
   logic        OUT_VALID;
   logic        OUT_READY;
   logic [10:0] OUT_FIELD;
   logic        OUT_LAST;
   logic        OUT_ERR;

   imm_encoder dut (
      .CLK       (CLK),
      .RESETn    (RESETn),
      .IN_VALID  (IN_VALID),
      .IN_READY  (IN_READY),
      .FMT       (FMT),
      .VALUE     (VALUE),
      .OUT_VALID (OUT_VALID),
      .OUT_READY (OUT_READY),
      .OUT_FIELD (OUT_FIELD),
      .OUT_LAST  (OUT_LAST),
      .OUT_ERR   (OUT_ERR)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   typedef struct {
      logic [10:0] f;
      logic        l;
      logic        e;
      string       name;
   } beat_t;

   beat_t sb[$];
   int    n_cmp = 0;
   int    n_bad = 0;

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h want 0x%0h", name, act, req);
      end
   endtask

   task automatic exp_beat(input string name, input logic [10:0] f,
                           input logic l, input logic e);
      beat_t b;
      b.f = f;
      b.l = l;
      b.e = e;
      b.name = name;
      sb.push_back(b);
   endtask

   // Monitor: sampled at negedge, between the stimulus edges
   initial begin : monitor
      logic        held;
      logic [12:0] held_v;
      beat_t       b;
      held = 1'b0;
      held_v = '0;
      forever begin
         @(negedge CLK);
         if (!RESETn) begin
            held = 1'b0;
         end else begin
            if (held) begin
               check("stall_hold", {18'b0, OUT_VALID, OUT_FIELD, OUT_LAST, OUT_ERR},
                     {18'b0, 1'b1, held_v});
            end
            held = OUT_VALID && !OUT_READY;
            held_v = {OUT_FIELD, OUT_LAST, OUT_ERR};
            if (OUT_VALID && OUT_READY) begin
               if (sb.size() == 0) begin
                  n_cmp++;
                  n_bad++;
                  $display("FAIL unexpected_beat: got field 0x%0h last %0b err %0b want none",
                           OUT_FIELD, OUT_LAST, OUT_ERR);
               end else begin
                  b = sb.pop_front();
                  check(b.name, {19'b0, OUT_FIELD, OUT_LAST, OUT_ERR},
                        {19'b0, b.f, b.l, b.e});
               end
            end
         end
      end
   end

   // Issue one request; inputs change #1 after posedge
   task automatic send(input logic [2:0] f, input logic [31:0] v);
      int t;
      t = 0;
      while (!IN_READY && t < 50) begin
         @(posedge CLK);
         #1;
         t++;
      end
      if (!IN_READY) begin
         check("ready_timeout", 32'(IN_READY), 32'd1);
      end
      IN_VALID = 1'b1;
      FMT = f;
      VALUE = v;
      @(posedge CLK);
      #1;
      IN_VALID = 1'b0;
      FMT = 3'd2;
      VALUE = 32'hDEAD_BEEF;
      check("latency1", 32'(OUT_VALID), 32'd1);
   endtask

   task automatic drain(input string name);
      int t;
      t = 0;
      while (sb.size() != 0 && t < 50) begin
         @(posedge CLK);
         #1;
         t++;
      end
      check({name, "_drained"}, sb.size(), 0);
      check({name, "_ready"}, 32'(IN_READY), 32'd1);
   endtask

   task automatic one(input string name, input logic [2:0] f,
                      input logic [31:0] v, input logic [10:0] field,
                      input logic e);
      exp_beat(name, field, 1'b1, e);
      send(f, v);
   endtask

   initial begin
      RESETn = 1'b0;
      IN_VALID = 1'b0;
      FMT = '0;
      VALUE = '0;
      OUT_READY = 1'b1;
      #13;
      check("rst_valid", 32'(OUT_VALID), 32'd0);
      check("rst_ready", 32'(IN_READY), 32'd0);
      check("rst_outs", {20'b0, OUT_FIELD, OUT_LAST}, 32'd0);
      @(posedge CLK);
      #1;
      RESETn = 1'b1;
      @(posedge CLK);
      #1;
      check("ready_after_rst", 32'(IN_READY), 32'd1);

      one("imm3_5",      3'd0, 32'd5,         11'h005, 1'b0);
      one("imm3_8",      3'd0, 32'd8,         11'h000, 1'b1);
      one("imm3_neg",    3'd0, 32'hFFFFFFFF,  11'h000, 1'b1);
      one("imm5_7c",     3'd1, 32'h7C,        11'h01F, 1'b0);
      one("imm5_80",     3'd1, 32'h80,        11'h000, 1'b1);
      one("imm5_7e",     3'd1, 32'h7E,        11'h000, 1'b1);
      one("imm5_0",      3'd1, 32'h0,         11'h000, 1'b0);
      one("imm8_min",    3'd2, 32'hFFFFFF00,  11'h080, 1'b0);
      one("imm8_under",  3'd2, 32'hFFFFFEFE,  11'h000, 1'b1);
      one("imm8_max",    3'd2, 32'h000000FE,  11'h07F, 1'b0);
      one("imm8_over",   3'd2, 32'h00000100,  11'h000, 1'b1);
      one("imm11_m4",    3'd3, 32'hFFFFFFFC,  11'h7FE, 1'b0);
      one("imm11_max",   3'd3, 32'h000007FE,  11'h3FF, 1'b0);
      one("imm11_over",  3'd3, 32'h00000800,  11'h000, 1'b1);
      one("imm11_min",   3'd3, 32'hFFFFF800,  11'h400, 1'b0);
      one("imm11_odd",   3'd3, 32'h00000003,  11'h000, 1'b1);
      one("rsv5",        3'd5, 32'h00000004,  11'h000, 1'b1);
      one("rsv6",        3'd6, 32'h12345678,  11'h000, 1'b1);
      one("rsv7",        3'd7, 32'h0,         11'h000, 1'b1);
      one("bl_over",     3'd4, 32'h00400000,  11'h000, 1'b1);
      one("bl_odd",      3'd4, 32'h00000001,  11'h000, 1'b1);
      drain("singles");

      exp_beat("bl_min_hi", 11'h400, 1'b0, 1'b0);
      exp_beat("bl_min_lo", 11'h000, 1'b1, 1'b0);
      send(3'd4, 32'hFFC00000);
      drain("bl_min");

      OUT_READY = 1'b0;
      exp_beat("bl_hi", 11'h123, 1'b0, 1'b0);
      exp_beat("bl_lo", 11'h22B, 1'b1, 1'b0);
      send(3'd4, 32'h00123456);
      repeat (3) begin
         @(posedge CLK);
         #1;
      end
      OUT_READY = 1'b1;
      drain("bl_bp");

      OUT_READY = 1'b0;
      send(3'd4, 32'h00123456);
      #2;
      RESETn = 1'b0;
      #1;
      check("midrst_valid", 32'(OUT_VALID), 32'd0);
      check("midrst_ready", 32'(IN_READY), 32'd0);
      check("midrst_outs", {20'b0, OUT_FIELD, OUT_LAST}, 32'd0);
      @(posedge CLK);
      #1;
      RESETn = 1'b1;
      OUT_READY = 1'b1;
      @(posedge CLK);
      #1;
      check("midrst_ready_after", 32'(IN_READY), 32'd1);
      repeat (4) begin
         @(posedge CLK);
         #1;
      end
      check("midrst_no_beat", 32'(OUT_VALID), 32'd0);

      one("post_rst_imm3", 3'd0, 32'd7, 11'h007, 1'b0);
      drain("final");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
